regbank_wr_arbiter: RTL and testbench
=====================================

// Module: regbank_wr_arbiter
// PURPOSE
//  Write-port scheduler for a bank of NREG 7-bit registers (register_7b-style cells with chosen/w_en/w_data).
//  Shares the single bank write path between two requesters, A (ALU writeback) and B (load unit), using round-robin.
//  Drives a registered one-hot select, write enable and write data into the bank, one write per cycle max.
//  Flags illegal addresses via err.
// PARAMETERS
//  NREG  8  number of registers in the bank (one chosen line each)
//  AW    3  address width; must satisfy 2**AW >= NREG
//  DW    7  data width; matches the bank register width
// PORTS
//  clk      in   1     clock, all state updates on rising edge
//  rst      in   1     reset, asynchronous, active-high
//  hold     in   1     datapath stall; 1 = issue no grants this cycle
//  req_a    in   1     requester A write request; held until gnt_a
//  addr_a   in   AW    requester A target register
//  data_a   in   DW    requester A write data
//  req_b    in   1     requester B write request; held until gnt_b
//  addr_b   in   AW    requester B target register
//  data_b   in   DW    requester B write data
//  gnt_a    out  1     combinational grant to A; addr_a/data_a consumed this cycle
//  gnt_b    out  1     combinational grant to B
//  chosen   out  NREG  registered one-hot register select to the bank
//  w_en     out  1     registered bank write enable
//  w_data   out  DW    registered bank write data
//  busy     out  1     registered; 1 while a write is in the issue stage
//  err      out  1     registered; 1-cycle pulse for a granted write with addr >= NREG
// BEHAVIOUR
//  Reset (async, rst=1): chosen=0, w_en=0, w_data=0, busy=0, err=0, FSM=IDLE, rr pointer=A (A wins next tie).
//  Reset mid-operation drops any write in the issue stage; no bank write occurs for it.
//  Grants are combinational from req_*, hold and rr pointer; at most one of gnt_a/gnt_b is 1 per cycle.
//   hold=1             -> no grant.
//   only one req       -> grant it.
//   both req           -> grant side pointed to by rr; rr flips to the other side after every grant.
//  Handshake: requester keeps req/addr/data stable until it sees gnt in the same cycle.
//   It may drop or change req on the following cycle.
//  Latency: grant in cycle T -> chosen/w_en/w_data valid in T+1.
//   The bank captures at the end of T+1; data is readable from the bank in T+2.
//  FSM (state register = issue stage owner):
//   IDLE  : no write issued. gnt_a -> ISS_A; gnt_b -> ISS_B; else IDLE.
//   ISS_A : outputs carry A's write. Next state follows this cycle's grant (ISS_A/ISS_B/IDLE).
//   ISS_B : same as ISS_A for B.
//   Back-to-back writes are allowed at 1 per cycle with no bubble.
//  Outputs per state: IDLE -> w_en=0, chosen=0, busy=0.
//   ISS_x with legal addr -> w_en=1, chosen=1<<addr, busy=1.
//  Illegal addr (addr >= NREG): grant still issued (requester is not stuck), FSM enters ISS_x.
//   In that case w_en=0, chosen=0, err=1 for that one cycle.
//  w_data holds its last value when no write is issued; the bank ignores it since w_en=0.
//  Same-address conflict: both req to same addr -> writes are serialized, rr winner first.
//   The later write's data is the final bank content.
//  hold asserted while ISS_x: the already-registered write still completes in that cycle; no new grant.
//  No address decode wraps: addr is never truncated modulo NREG.
// TESTING
//  reset: rst=1 mid-write (ISS_A, addr=3) -> all outputs 0 immediately; bank reg 3 unchanged.
//  single: req_a=1 addr_a=2 data_a=7'h55 -> gnt_a in T; chosen=8'b0000_0100, w_en=1, w_data=7'h55 in T+1.
//  tie: req_a,req_b both held 4 cycles from reset -> grants A,B,A,B; w_en=1 for 4 consecutive cycles.
//  conflict: A(addr 5,7'h11) and B(addr 5,7'h22) together from reset -> bank reg 5 = 7'h22 finally.
//  hold: hold=1 with req_b=1 for 3 cycles -> gnt_b=0 throughout; grant in the cycle hold drops.
//  illegal: NREG=6, req_a addr_a=7 -> gnt_a=1; next cycle err=1, w_en=0, chosen=0; err back to 0 after.

Source files
------------

// File: rtl/regbank_wr_arbiter_if.sv
// Write-request bus between the two requesters (A: ALU writeback, B: load unit) and the
// register-bank write scheduler, plus the registered bank-side write port.
interface regbank_wr_arbiter_if #(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 7
);
  logic            hold;
  logic            req_a;
  logic [AW-1:0]   addr_a;
  logic [DW-1:0]   data_a;
  logic            req_b;
  logic [AW-1:0]   addr_b;
  logic [DW-1:0]   data_b;
  logic            gnt_a;
  logic            gnt_b;
  logic [NREG-1:0] chosen;
  logic            w_en;
  logic [DW-1:0]   w_data;
  logic            busy;
  logic            err;

  modport master (
    output hold, req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  gnt_a, gnt_b, chosen, w_en, w_data, busy, err
  );

  modport slave (
    input  hold, req_a, addr_a, data_a, req_b, addr_b, data_b,
    output gnt_a, gnt_b, chosen, w_en, w_data, busy, err
  );
endinterface

// File: rtl/regbank_wr_arbiter.sv
// Round-robin scheduler sharing the single register-bank write path between requesters A and B.
// Grants are combinational; the winning write is registered into a one-cycle issue stage.
module regbank_wr_arbiter #(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 7
) (
  input logic               clk,
  input logic               rst,
  regbank_wr_arbiter_if.slave bus
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISS_A = 2'b01,
    S_ISS_B = 2'b10
  } state_e;

  state_e          state_q;
  logic            rr_b_q;      // 1: B wins the next tie
  logic [NREG-1:0] chosen_q;
  logic            w_en_q;
  logic            err_q;
  logic [DW-1:0]   w_data_q;

  logic            gnt_a_c;
  logic            gnt_b_c;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            win_legal;

  // Grant selection and mux of the winning request
  always_comb begin
    gnt_a_c   = 1'b0;
    gnt_b_c   = 1'b0;
    win_addr  = bus.addr_a;
    win_data  = bus.data_a;
    win_legal = 1'b0;
    if (!bus.hold) begin
      gnt_a_c = bus.req_a && (!bus.req_b || !rr_b_q);
      gnt_b_c = bus.req_b && (!bus.req_a ||  rr_b_q);
    end
    if (gnt_b_c) begin
      win_addr = bus.addr_b;
      win_data = bus.data_b;
    end
    // Full-width compare: out-of-range addresses are flagged, never wrapped
    win_legal = ((AW+1)'(win_addr) < NREG_W);
  end

  // Issue stage: state tracks which requester owns the registered write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_b_q   <= 1'b0;
      chosen_q <= '0;
      w_en_q   <= 1'b0;
      err_q    <= 1'b0;
      w_data_q <= '0;
    end else if (gnt_a_c || gnt_b_c) begin
      state_q  <= gnt_b_c ? S_ISS_B : S_ISS_A;
      rr_b_q   <= gnt_a_c;
      w_data_q <= win_data;
      w_en_q   <= win_legal;
      chosen_q <= win_legal ? (NREG'(1) << win_addr) : '0;
      err_q    <= !win_legal;
    end else begin
      state_q  <= S_IDLE;
      chosen_q <= '0;
      w_en_q   <= 1'b0;
      err_q    <= 1'b0;
    end
  end

  assign bus.gnt_a  = gnt_a_c;
  assign bus.gnt_b  = gnt_b_c;
  assign bus.chosen = chosen_q;
  assign bus.w_en   = w_en_q;
  assign bus.w_data = w_data_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: an NREG=8 and an NREG=6 instance share one stimulus stream and
// are checked against a transaction-level model plus a behavioural register bank per instance.
module tb_regbank_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       t_hold = 1'b0, t_ra = 1'b0, t_rb = 1'b0;
  logic [2:0] t_aa = '0, t_ab = '0;
  logic [6:0] t_da = '0, t_db = '0;

  regbank_wr_arbiter_if #(.NREG(8), .AW(3), .DW(7)) if8 ();
  regbank_wr_arbiter_if #(.NREG(6), .AW(3), .DW(7)) if6 ();

  assign if8.hold = t_hold; assign if8.req_a = t_ra; assign if8.addr_a = t_aa; assign if8.data_a = t_da;
  assign if8.req_b = t_rb;  assign if8.addr_b = t_ab; assign if8.data_b = t_db;
  assign if6.hold = t_hold; assign if6.req_a = t_ra; assign if6.addr_a = t_aa; assign if6.data_a = t_da;
  assign if6.req_b = t_rb;  assign if6.addr_b = t_ab; assign if6.data_b = t_db;

  regbank_wr_arbiter #(.NREG(8), .AW(3), .DW(7)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  regbank_wr_arbiter #(.NREG(6), .AW(3), .DW(7)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));

  // Downstream banks: capture w_data into the selected register at the clock edge
  logic [6:0] bank8 [8] = '{default: '0};
  logic [6:0] bank6 [6] = '{default: '0};
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (if8.w_en && if8.chosen[i]) bank8[i] <= if8.w_data;
    for (int i = 0; i < 6; i++) if (if6.w_en && if6.chosen[i]) bank6[i] <= if6.w_data;
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: pending issued write, tie priority, and expected bank contents
  bit         prio_a = 1'b1;
  bit         iss_v = 1'b0;
  logic [2:0] iss_addr = '0;
  logic [6:0] iss_data = '0;
  logic [6:0] last_data = '0;
  logic [6:0] mem8 [8] = '{default: '0};
  logic [6:0] mem6 [6] = '{default: '0};
  bit         obs_ga, obs_gb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    iss_v = 1'b0; last_data = '0; prio_a = 1'b1;
  endtask

  task automatic model_step(input bit ga, input bit gb);
    if (iss_v) begin
      if (iss_addr < 8) mem8[iss_addr] = iss_data;
      if (iss_addr < 6) mem6[iss_addr] = iss_data;
    end
    if (ga) begin
      iss_v = 1'b1; iss_addr = t_aa; iss_data = t_da; last_data = t_da; prio_a = 1'b0;
    end else if (gb) begin
      iss_v = 1'b1; iss_addr = t_ab; iss_data = t_db; last_data = t_db; prio_a = 1'b1;
    end else begin
      iss_v = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit wen8, wen6;
    wen8 = iss_v && (iss_addr < 8);
    wen6 = iss_v && (iss_addr < 6);
    chk("w_en8",   32'(if8.w_en),   32'(wen8));
    chk("chosen8", 32'(if8.chosen), wen8 ? (32'd1 << iss_addr) : 32'd0);
    chk("w_data8", 32'(if8.w_data), 32'(last_data));
    chk("err8",    32'(if8.err),    32'(iss_v && !wen8));
    chk("busy8",   32'(if8.busy),   32'(iss_v));
    chk("w_en6",   32'(if6.w_en),   32'(wen6));
    chk("chosen6", 32'(if6.chosen), wen6 ? (32'd1 << iss_addr) : 32'd0);
    chk("w_data6", 32'(if6.w_data), 32'(last_data));
    chk("err6",    32'(if6.err),    32'(iss_v && !wen6));
    chk("busy6",   32'(if6.busy),   32'(iss_v));
  endtask

  task automatic check_banks();
    for (int i = 0; i < 8; i++) chk($sformatf("bank8[%0d]", i), 32'(bank8[i]), 32'(mem8[i]));
    for (int i = 0; i < 6; i++) chk($sformatf("bank6[%0d]", i), 32'(bank6[i]), 32'(mem6[i]));
  endtask

  // One clock cycle: drive at negedge, check grants, step model at posedge, check outputs
  task automatic apply(input bit h, input bit ra, input logic [2:0] aa, input logic [6:0] da,
                       input bit rb, input logic [2:0] ab, input logic [6:0] db);
    bit ga_m, gb_m;
    t_hold = h; t_ra = ra; t_aa = aa; t_da = da; t_rb = rb; t_ab = ab; t_db = db;
    #1;
    ga_m = !h && ra && (!rb || prio_a);
    gb_m = !h && rb && (!ra || !prio_a);
    obs_ga = if8.gnt_a; obs_gb = if8.gnt_b;
    chk("gnt_a8", 32'(if8.gnt_a), 32'(ga_m));
    chk("gnt_b8", 32'(if8.gnt_b), 32'(gb_m));
    chk("gnt_a6", 32'(if6.gnt_a), 32'(ga_m));
    chk("gnt_b6", 32'(if6.gnt_b), 32'(gb_m));
    @(posedge clk);
    model_step(ga_m, gb_m);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 3'd0, 7'h00);
  endtask

  // Asserted at a negedge so a write sitting in the issue stage is dropped before the bank edge
  task automatic do_reset();
    rst = 1'b1;
    t_hold = 1'b0; t_ra = 1'b0; t_rb = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         hold, ra;
    logic [2:0] aa;
    logic [6:0] da;
    bit         rb;
    logic [2:0] ab;
    logic [6:0] db;
    bit         eg_a, eg_b, ewen8;
    logic [7:0] ech8;
    logic [6:0] ewd;
    bit         eerr6;
  } vec_t;

  vec_t tbl [10];
  logic [6:0] saved;
  bit pa, pb;
  logic [2:0] paa, pab;
  logic [6:0] pda, pdb;

  initial begin
    // hold ra aa da rb ab db | gnt_a gnt_b | w_en8 chosen8 w_data err6 (next cycle)
    tbl[0] = '{0, 1, 3'd2, 7'h55, 0, 3'd0, 7'h00, 1, 0, 1, 8'h04, 7'h55, 0};
    tbl[1] = '{0, 0, 3'd0, 7'h00, 0, 3'd0, 7'h00, 0, 0, 0, 8'h00, 7'h55, 0};
    tbl[2] = '{0, 1, 3'd1, 7'h0a, 1, 3'd3, 7'h0b, 0, 1, 1, 8'h08, 7'h0b, 0};
    tbl[3] = '{0, 1, 3'd1, 7'h0a, 1, 3'd4, 7'h0c, 1, 0, 1, 8'h02, 7'h0a, 0};
    tbl[4] = '{1, 1, 3'd2, 7'h0d, 1, 3'd4, 7'h0c, 0, 0, 0, 8'h00, 7'h0a, 0};
    tbl[5] = '{0, 1, 3'd2, 7'h0d, 1, 3'd4, 7'h0c, 0, 1, 1, 8'h10, 7'h0c, 0};
    tbl[6] = '{0, 1, 3'd2, 7'h0d, 0, 3'd0, 7'h00, 1, 0, 1, 8'h04, 7'h0d, 0};
    tbl[7] = '{0, 0, 3'd0, 7'h00, 1, 3'd7, 7'h7f, 0, 1, 1, 8'h80, 7'h7f, 1};
    tbl[8] = '{0, 1, 3'd6, 7'h66, 0, 3'd0, 7'h00, 1, 0, 1, 8'h40, 7'h66, 1};
    tbl[9] = '{0, 0, 3'd0, 7'h00, 0, 3'd0, 7'h00, 0, 0, 0, 8'h00, 7'h66, 0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].hold, tbl[i].ra, tbl[i].aa, tbl[i].da, tbl[i].rb, tbl[i].ab, tbl[i].db);
      chk($sformatf("tbl%0d.gnt_a", i),  32'(obs_ga),      32'(tbl[i].eg_a));
      chk($sformatf("tbl%0d.gnt_b", i),  32'(obs_gb),      32'(tbl[i].eg_b));
      chk($sformatf("tbl%0d.w_en8", i),  32'(if8.w_en),    32'(tbl[i].ewen8));
      chk($sformatf("tbl%0d.chosen8", i), 32'(if8.chosen), 32'(tbl[i].ech8));
      chk($sformatf("tbl%0d.w_data", i), 32'(if8.w_data),  32'(tbl[i].ewd));
      chk($sformatf("tbl%0d.err6", i),   32'(if6.err),     32'(tbl[i].eerr6));
    end

    // Tie from reset: A,B,A,B with a bank write every cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 3'd1, 7'h31, 1'b1, 3'd2, 7'h32);
      chk($sformatf("tie%0d.gnt_a", i), 32'(obs_ga), 32'((i % 2) == 0));
      chk($sformatf("tie%0d.gnt_b", i), 32'(obs_gb), 32'((i % 2) == 1));
      chk($sformatf("tie%0d.w_en", i),  32'(if8.w_en), 32'd1);
    end

    // Same-address conflict: B's data is the final content
    do_reset();
    apply(1'b0, 1'b1, 3'd5, 7'h11, 1'b1, 3'd5, 7'h22);
    apply(1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 3'd5, 7'h22);
    idle();
    idle();
    chk("conflict.bank8[5]", 32'(bank8[5]), 32'h22);
    chk("conflict.bank6[5]", 32'(bank6[5]), 32'h22);
    check_banks();

    // Hold stalls B for three cycles, grant follows as soon as hold drops
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 3'd0, 7'h00, 1'b1, 3'd1, 7'h44);
      chk($sformatf("hold%0d.gnt_b", i), 32'(obs_gb), 32'd0);
    end
    apply(1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 3'd1, 7'h44);
    chk("hold.release.gnt_b", 32'(obs_gb), 32'd1);
    chk("hold.release.w_en",  32'(if8.w_en), 32'd1);

    // Illegal address on the NREG=6 instance
    do_reset();
    apply(1'b0, 1'b1, 3'd7, 7'h5a, 1'b0, 3'd0, 7'h00);
    chk("illegal.gnt_a",   32'(obs_ga),     32'd1);
    chk("illegal.err6",    32'(if6.err),    32'd1);
    chk("illegal.w_en6",   32'(if6.w_en),   32'd0);
    chk("illegal.chosen6", 32'(if6.chosen), 32'd0);
    chk("illegal.w_en8",   32'(if8.w_en),   32'd1);
    idle();
    chk("illegal.err6.after", 32'(if6.err), 32'd0);

    // Reset while a write to reg 3 sits in the issue stage
    do_reset();
    idle();
    saved = bank8[3];
    apply(1'b0, 1'b1, 3'd3, (saved ^ 7'h33), 1'b0, 3'd0, 7'h00);
    chk("midrst.w_en_before", 32'(if8.w_en), 32'd1);
    do_reset();
    chk("midrst.chosen", 32'(if8.chosen), 32'd0);
    chk("midrst.w_data", 32'(if8.w_data), 32'd0);
    idle();
    chk("midrst.bank8[3]", 32'(bank8[3]), 32'(saved));
    check_banks();

    // Random traffic obeying the hold-until-grant handshake
    do_reset();
    pa = 1'b0; pb = 1'b0; paa = '0; pab = '0; pda = '0; pdb = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pa && $urandom_range(0, 99) < 55) begin
        pa = 1'b1; paa = 3'($urandom_range(0, 7)); pda = 7'($urandom);
      end
      if (!pb && $urandom_range(0, 99) < 55) begin
        pb = 1'b1; pab = 3'($urandom_range(0, 7)); pdb = 7'($urandom);
      end
      apply(($urandom_range(0, 99) < 20), pa, paa, pda, pb, pab, pdb);
      if (obs_ga) pa = 1'b0;
      if (obs_gb) pb = 1'b0;
    end
    idle();
    idle();
    check_banks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
